// File: rtl/adc_capture_pkg.sv
// Shared types and default constants for the ADC capture sequencer.
`timescale 1ns/1ps
package adc_capture_pkg;

    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned CLK_DIV_DEF    = 5000;   // 10 kHz ADC_CLK from 100 MHz CLK
    localparam int unsigned DEPTH_BITS_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } cap_state_e;

    function automatic logic is_busy(input cap_state_e s);
        return (s == ST_PRE) || (s == ST_WAIT_TRIG) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/adc_clk_gen.sv
// ADC sample clock divider; sample_tick is high in the CLK cycle whose closing edge drops ADC_CLK.
`timescale 1ns/1ps
module adc_clk_gen
    import adc_capture_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic CLK,
    input  logic nRST,
    output logic ADC_CLK,
    output logic sample_tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt         <= '0;
            ADC_CLK     <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            // Registered one cycle ahead so the tick lines up with the terminal-count edge.
            sample_tick <= (cnt == CNT_W'(CLK_DIV - 2)) && ADC_CLK;
            if (cnt == CNT_W'(CLK_DIV - 1)) begin
                cnt     <= '0;
                ADC_CLK <= ~ADC_CLK;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Level-trigger capture sequencer writing ADC samples into a circular buffer.
// Pre-trigger capture is enabled by defining ADC_CAPTURE_PRETRIG_EN.
`timescale 1ns/1ps
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter int unsigned DEPTH_BITS = DEPTH_BITS_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  ARM,
    input  logic                  ABORT,
    input  logic [DATA_W-1:0]     TRIG_LEVEL,
    input  logic                  TRIG_RISING,
    input  logic [DEPTH_BITS-1:0] POST_COUNT,
    input  logic [DATA_W-1:0]     ADC_D,
    output logic                  ADC_CLK,
    output logic                  ADC_nOE,
    output logic                  WR_EN,
    output logic [DEPTH_BITS-1:0] WR_ADDR,
    output logic [DATA_W-1:0]     WR_DATA,
    output logic [DEPTH_BITS-1:0] TRIG_ADDR,
    output logic                  BUSY,
    output logic                  DONE
);

    logic sample_tick;

    adc_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .CLK         (CLK),
        .nRST        (nRST),
        .ADC_CLK     (ADC_CLK),
        .sample_tick (sample_tick)
    );

    cap_state_e            state_q, state_d;
    logic [DATA_W-1:0]     level_q, level_d;
    logic                  rising_q, rising_d;
    logic [DEPTH_BITS-1:0] post_q, post_d;
    logic [DEPTH_BITS-1:0] ptr_q, ptr_d;
    logic [DEPTH_BITS-1:0] post_cnt_q, post_cnt_d;
    logic [DATA_W-1:0]     prev_q, prev_d;
    logic                  prev_valid_q, prev_valid_d;
`ifdef ADC_CAPTURE_PRETRIG_EN
    logic [DEPTH_BITS-1:0] pre_cnt_q, pre_cnt_d;
`endif
    logic                  wr_en_d;
    logic [DEPTH_BITS-1:0] wr_addr_d;
    logic [DATA_W-1:0]     wr_data_d;
    logic [DEPTH_BITS-1:0] trig_addr_d;
    logic                  do_write;
    logic                  trig_hit;
    logic                  arm_go;

    assign arm_go = ARM && !ABORT;

    // Crossing detect against the previous sample; the first sample after ARM only primes prev.
    always_comb begin
        trig_hit = 1'b0;
        if (prev_valid_q) begin
            if (rising_q) trig_hit = (prev_q <  level_q) && (ADC_D >= level_q);
            else          trig_hit = (prev_q >= level_q) && (ADC_D <  level_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        rising_d     = rising_q;
        post_d       = post_q;
        ptr_d        = ptr_q;
        post_cnt_d   = post_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
`ifdef ADC_CAPTURE_PRETRIG_EN
        pre_cnt_d    = pre_cnt_q;
`endif
        wr_en_d      = 1'b0;
        wr_addr_d    = WR_ADDR;
        wr_data_d    = WR_DATA;
        trig_addr_d  = TRIG_ADDR;
        do_write     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_go) begin
                    level_d      = TRIG_LEVEL;
                    rising_d     = TRIG_RISING;
                    post_d       = POST_COUNT;
                    ptr_d        = '0;
                    prev_valid_d = 1'b0;
`ifdef ADC_CAPTURE_PRETRIG_EN
                    pre_cnt_d    = '0;
                    // Pre-trigger length is N-1-POST_COUNT, i.e. ~POST_COUNT.
                    state_d      = (POST_COUNT == '1) ? ST_WAIT_TRIG : ST_PRE;
`else
                    state_d      = ST_WAIT_TRIG;
`endif
                end
            end
`ifdef ADC_CAPTURE_PRETRIG_EN
            ST_PRE: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (sample_tick) begin
                    do_write  = 1'b1;
                    pre_cnt_d = pre_cnt_q + DEPTH_BITS'(1);
                    if (pre_cnt_d == DEPTH_BITS'(~post_q)) state_d = ST_WAIT_TRIG;
                end
            end
`endif
            ST_WAIT_TRIG: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (sample_tick) begin
`ifdef ADC_CAPTURE_PRETRIG_EN
                    do_write = 1'b1;
`else
                    do_write = trig_hit;
`endif
                    if (trig_hit) begin
                        trig_addr_d = ptr_q;
                        post_cnt_d  = post_q;
                        state_d     = ST_POST;
                    end
                end
            end
            ST_POST: begin
                // A zero count means the final write is on the bus now; DONE follows it.
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (post_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else if (sample_tick) begin
                    do_write   = 1'b1;
                    post_cnt_d = post_cnt_q - DEPTH_BITS'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = ADC_D;
            ptr_d     = ptr_q + DEPTH_BITS'(1);
        end

        if (sample_tick && is_busy(state_q) && !ABORT) begin
            prev_d       = ADC_D;
            prev_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            level_q      <= '0;
            rising_q     <= 1'b0;
            post_q       <= '0;
            ptr_q        <= '0;
            post_cnt_q   <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
`ifdef ADC_CAPTURE_PRETRIG_EN
            pre_cnt_q    <= '0;
`endif
            WR_EN        <= 1'b0;
            WR_ADDR      <= '0;
            WR_DATA      <= '0;
            TRIG_ADDR    <= '0;
            ADC_nOE      <= 1'b1;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            rising_q     <= rising_d;
            post_q       <= post_d;
            ptr_q        <= ptr_d;
            post_cnt_q   <= post_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
`ifdef ADC_CAPTURE_PRETRIG_EN
            pre_cnt_q    <= pre_cnt_d;
`endif
            WR_EN        <= wr_en_d;
            WR_ADDR      <= wr_addr_d;
            WR_DATA      <= wr_data_d;
            TRIG_ADDR    <= trig_addr_d;
            ADC_nOE      <= !is_busy(state_d);
            BUSY         <= is_busy(state_d);
            DONE         <= (state_d == ST_DONE);
        end
    end

endmodule
